// File: rtl/bus_defines_pkg.sv
// Shared bus constants and FSM state type for the 4-master/8-slave bus and its adapters.
// Every control strobe on this bus is active-low.
package bus_defines;

   localparam int unsigned ADDR_W = 30;
   localparam int unsigned DATA_W = 32;

   localparam logic READ     = 1'b1;
   localparam logic WRITE    = 1'b0;
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_ACCESS = 2'd2,
      ST_WAIT   = 2'd3
   } bus_state_e;

endpackage

// File: rtl/bus_master_if.sv
// Initiator-side adapter: turns one core access into req_/grnt_/as_/rdy_ bus handshake,
// with optional bus lock across back-to-back accesses and a ready watchdog.
module bus_master_if
   import bus_defines::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned TO_W        = 8,
   parameter int unsigned LOCK_EN     = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic              core_rw,
   input  logic [DATA_W-1:0] core_wr_data,
   output logic              core_busy,
   output logic              core_done,
   output logic              core_err,
   output logic [DATA_W-1:0] core_rd_data,
   output logic              bus_req_,
   input  logic              bus_grnt_,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_as_,
   output logic              bus_rw,
   output logic [DATA_W-1:0] bus_wr_data,
   input  logic [DATA_W-1:0] bus_rd_data,
   input  logic              bus_rdy_
);

   localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYC - 1);

   bus_state_e        st_q, st_d;
   logic              req_q, req_d;
   logic              as_q, as_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [TO_W-1:0]   wd_q, wd_d;
   logic              rdy_hit, wd_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q    <= ST_IDLE;
         req_q   <= DISABLE_;
         as_q    <= DISABLE_;
         rw_q    <= READ;
         addr_q  <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         wd_q    <= '0;
      end else begin
         st_q    <= st_d;
         req_q   <= req_d;
         as_q    <= as_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         wd_q    <= wd_d;
      end
   end

   // as_ is registered, so it is asserted on the edge that enters ACCESS.
   always_comb begin
      st_d    = st_q;
      req_d   = req_q;
      as_d    = DISABLE_;
      rw_d    = rw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      rdata_d = rdata_q;
      wd_d    = wd_q;
      rdy_hit = 1'b0;
      wd_hit  = 1'b0;

      case (st_q)
         ST_IDLE: begin
            if (core_req) begin
               addr_d  = core_addr;
               rw_d    = core_rw;
               wdata_d = core_wr_data;
               busy_d  = 1'b1;
               req_d   = ENABLE_;
               if (bus_grnt_ == ENABLE_) begin
                  st_d = ST_ACCESS;
                  as_d = ENABLE_;
               end else begin
                  st_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (bus_grnt_ == ENABLE_) begin
               st_d = ST_ACCESS;
               as_d = ENABLE_;
            end
         end
         ST_ACCESS: begin
            st_d = ST_WAIT;
            wd_d = '0;
         end
         ST_WAIT: begin
            rdy_hit = (bus_rdy_ == ENABLE_);
            wd_hit  = !rdy_hit && (wd_q == WD_LAST);
            if (rdy_hit || wd_hit) begin
               done_d = 1'b1;
               err_d  = wd_hit;
               if (rdy_hit && rw_q == READ) begin
                  rdata_d = bus_rd_data;
               end
               // Timeout never chains, so a dead slave cannot keep the bus locked.
               if (LOCK_EN != 0 && rdy_hit && core_req) begin
                  addr_d  = core_addr;
                  rw_d    = core_rw;
                  wdata_d = core_wr_data;
                  as_d    = ENABLE_;
                  st_d    = ST_ACCESS;
               end else begin
                  req_d  = DISABLE_;
                  busy_d = 1'b0;
                  st_d   = ST_IDLE;
               end
            end else if (wd_q != '1) begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   assign core_busy    = busy_q;
   assign core_done    = done_q;
   assign core_err     = err_q;
   assign core_rd_data = rdata_q;
   assign bus_req_     = req_q;
   assign bus_as_      = as_q;
   assign bus_rw       = rw_q;
   assign bus_addr     = addr_q;
   assign bus_wr_data  = wdata_q;

endmodule
